booth_mac_acc: RTL and testbench
================================

// Module: booth_mac_acc
// PURPOSE
// - Signed accumulator that sits directly downstream of the 16x16 radix-4 Booth multiplier.
// - Takes the 32-bit two's-complement product z, one beat per valid/ready handshake, and sums a group of beats.
// - Returns the group sum and a term count on a valid/ready output.
// - Turns the combinational multiplier into a pipelined MAC / dot-product engine.
// PARAMETERS
// - ACC_W      40   accumulator / result width in bits; must be >= 33.
// - MAX_TERMS  256  a group is forced closed when this many terms have been summed.
// - CNT_W      9    term-counter width; must satisfy 2**CNT_W > MAX_TERMS.
// PORTS
// - clk        in   1      single clock; all flops rising-edge.
// - rst_n      in   1      asynchronous, active-low reset.
// - in_valid   in   1      in_prod/in_last valid.
// - in_ready   out  1      block can accept a beat; transfer when in_valid & in_ready.
// - in_prod    in   32     signed product (multiplier z).
// - in_last    in   1      beat closes the current group.
// - out_valid  out  1      out_acc/out_cnt/out_ovf valid; held until out_ready.
// - out_ready  in   1      consumer accepts; transfer when out_valid & out_ready.
// - out_acc    out  ACC_W  signed group sum.
// - out_cnt    out  CNT_W  number of terms in the group (1..MAX_TERMS).
// - out_ovf    out  1      signed overflow occurred at some add in this group.
// BEHAVIOUR
// - Reset (async, rst_n=0): every flop clears.
//   - out_valid=0, out_acc=0, out_cnt=0, out_ovf=0; in_ready=1 after release.
//   - Stage-1 register empty; FSM in ACC.
// - Stage 1 (input register): p_vld/p_prod/p_last.
//   - Loaded on an in handshake.
//   - in_ready = !p_vld | (state==ACC), so stage 1 buffers one beat while the FSM is in DONE.
// - Stage 2 FSM, 2 states:
//   - ACC: when p_vld, consume it: acc += sext(p_prod) to ACC_W, cnt += 1, ovf |= add_ovf.
//     - If p_last, or cnt+1 == MAX_TERMS, go to DONE.
//   - DONE: out_valid=1. out_acc/out_cnt/out_ovf are the acc/cnt/ovf registers, stable while out_valid & !out_ready.
//     - On out_ready: acc=0, cnt=0, ovf=0, go to ACC.
//     - Stage 1 is not consumed in DONE.
// - Latency: in_last accepted at edge N -> consumed at N+1 -> out_valid=1 from after edge N+1 (2 cycles).
// - Throughput: 1 beat/cycle in ACC; a group costs >= 1 extra cycle for the DONE handshake.
// - Simultaneous events:
//   - In DONE with out_ready=1 and p_vld=1: the FSM returns to ACC this edge and consumes p next cycle. No beat is lost or duplicated.
//   - A new in beat may load stage 1 in the same cycle stage 1 is consumed.
// - Forced close at MAX_TERMS: the group is emitted with out_cnt=MAX_TERMS.
//   - The next beat starts a new group even if in_last was never seen.
// - add_ovf: operand signs are equal and the result sign differs (signed ACC_W add).
// - in_prod is treated as signed; the product 0x40000000 (-32768*-32768) is legal and positive.
// - Reset mid-group discards the partial sum and any beat held in stage 1.
// CONFIGURATION
// - BOOTH_MAC_SAT_EN defined: each add that overflows clamps acc to +(2^(ACC_W-1)-1) or -2^(ACC_W-1) by the direction of overflow; out_ovf=1.
//   - Once saturated, further adds continue from the clamped value.
// - BOOTH_MAC_SAT_EN undefined: adds wrap modulo 2^ACC_W; out_ovf still reports overflow.
// TESTING
// - Reset: rst_n low mid-group with p_vld=1 -> out_valid=0, in_ready=1, next group sums from 0.
// - Single-beat group: in_prod=0xFFFFFFFF(-1), in_last=1 -> 2 cycles later out_acc=-1 (sign-extended), out_cnt=1, out_ovf=0.
// - Back-to-back group: beats 100, -300, 0x40000000 (last) with out_ready=1 -> out_acc=0x3FFFFF38, out_cnt=3.
//   - The next group begins with no dropped beat.
// - Backpressure: out_ready=0 for 5 cycles -> outputs stable, stage 1 holds one beat, in_ready=0.
//   - out_ready=1 -> that beat is consumed as term 1 of the next group.
// - MAX_TERMS=4, five beats of 1, no in_last -> group 1: out_acc=4, out_cnt=4; the 5th beat opens group 2.
// - ACC_W=33, two beats of 0x7FFFFFFF:
//   - With BOOTH_MAC_SAT_EN: sum 0xFFFFFFFE, out_ovf=0.
//   - Then +0x7FFFFFFF: saturates to 0x0FFFFFFFF with out_ovf=1 when SAT_EN is defined; wraps negative with out_ovf=1 when it is not.

Source files
------------

// File: rtl/booth_mac_acc.sv
// booth_mac_acc: signed group accumulator placed after the 16x16 radix-4
// Booth multiplier. Accepts 32-bit signed products, sums them per group and
// emits {sum, term count, overflow flag} on a valid/ready output.
//
// Build option: define BOOTH_MAC_SAT_EN to clamp the accumulator on signed
// overflow; otherwise adds wrap modulo 2**ACC_W. out_ovf reports overflow
// in both builds.
//
// Handshake rule (both ports): a beat transfers on a rising edge where
// valid & ready are both high; a valid source holds its payload stable
// until that edge, and ready may depend on internal state only.
//
// Parameter constraints: ACC_W >= 33, 2**CNT_W > MAX_TERMS.
module booth_mac_acc #(
    parameter int ACC_W     = 40,
    parameter int MAX_TERMS = 256,
    parameter int CNT_W     = 9
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_prod,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_acc,
    output logic [CNT_W-1:0] out_cnt,
    output logic             out_ovf,
    output logic             dbg_state
);

    typedef enum logic {
        ST_ACC  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

`ifdef BOOTH_MAC_SAT_EN
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_t            state;
    logic              p_vld;
    logic [31:0]       p_prod;
    logic              p_last;
    logic [ACC_W-1:0]  acc;
    logic [CNT_W-1:0]  cnt;
    logic              ovf;

    logic [ACC_W-1:0]  p_ext;
    logic [ACC_W-1:0]  sum;
    logic [ACC_W-1:0]  acc_nxt;
    logic [CNT_W-1:0]  cnt_inc;
    logic              add_ovf;
    logic              consume;
    logic              close_grp;
    logic              in_fire;

    // Stage 1 may refill whenever it is empty or being drained by the ACC state.
    assign in_ready  = !p_vld || (state == ST_ACC);
    assign in_fire   = in_valid && in_ready;
    assign consume   = (state == ST_ACC) && p_vld;

    assign p_ext     = {{(ACC_W-32){p_prod[31]}}, p_prod};
    assign sum       = acc + p_ext;
    assign add_ovf   = (acc[ACC_W-1] == p_ext[ACC_W-1]) && (sum[ACC_W-1] != acc[ACC_W-1]);
    assign cnt_inc   = cnt + CNT_W'(1);
    assign close_grp = p_last || (cnt_inc == CNT_W'(MAX_TERMS));

    // Next accumulator value: plain wrap, or clamp toward the overflow direction.
    always_comb begin
        acc_nxt = sum;
`ifdef BOOTH_MAC_SAT_EN
        if (add_ovf) begin
            acc_nxt = acc[ACC_W-1] ? ACC_MIN : ACC_MAX;
        end
`endif
    end

    // Stage 1 input register: loads on an input transfer, empties when consumed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_vld  <= 1'b0;
            p_prod <= '0;
            p_last <= 1'b0;
        end else if (in_fire) begin
            p_vld  <= 1'b1;
            p_prod <= in_prod;
            p_last <= in_last;
        end else if (consume) begin
            p_vld  <= 1'b0;
        end
    end

    // Stage 2 FSM: accumulate in ACC, present the group result in DONE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            ovf       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_ACC: begin
                    if (consume) begin
                        acc <= acc_nxt;
                        cnt <= cnt_inc;
                        ovf <= ovf | add_ovf;
                        if (close_grp) begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        acc       <= '0;
                        cnt       <= '0;
                        ovf       <= 1'b0;
                        out_valid <= 1'b0;
                        state     <= ST_ACC;
                    end
                end
                default: begin
                    state     <= ST_ACC;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign out_acc   = acc;
    assign out_cnt   = cnt;
    assign out_ovf   = ovf;
    assign dbg_state = logic'(state);

endmodule

// File: tb/tb_booth_mac_acc.sv
// Bench for booth_mac_acc: instance A uses default parameters, instance B
// uses ACC_W=33, MAX_TERMS=4 for overflow and forced-close corners.
// Expected results come from an arithmetic group model (integer sums with
// range checks) kept in per-instance expected queues.
module tb_booth_mac_acc;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // instance A signals
  logic        a_in_valid, a_in_ready, a_in_last, a_out_valid, a_out_ready, a_out_ovf, a_dbg;
  logic [31:0] a_in_prod;
  logic [39:0] a_out_acc;
  logic [8:0]  a_out_cnt;
  // instance B signals
  logic        b_in_valid, b_in_ready, b_in_last, b_out_valid, b_out_ready, b_out_ovf, b_dbg;
  logic [31:0] b_in_prod;
  logic [32:0] b_out_acc;
  logic [2:0]  b_out_cnt;

  booth_mac_acc dut_a (
    .clk(clk), .rst_n(rst_n),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_prod(a_in_prod), .in_last(a_in_last),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_acc(a_out_acc),
    .out_cnt(a_out_cnt), .out_ovf(a_out_ovf), .dbg_state(a_dbg)
  );

  booth_mac_acc #(.ACC_W(33), .MAX_TERMS(4), .CNT_W(3)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_prod(b_in_prod), .in_last(b_in_last),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_acc(b_out_acc),
    .out_cnt(b_out_cnt), .out_ovf(b_out_ovf), .dbg_state(b_dbg)
  );

  int n_checks = 0;
  int n_fail = 0;
  logic [49:0] exp_a_q[$];
  logic [49:0] exp_b_q[$];
  longint m_acc[2];
  int     m_cnt[2];
  bit     m_ovf[2];
  bit     a_fire, b_fire;
  bit     rand_ready = 1'b0;

  // watchdog
  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [49:0] obs, input logic [49:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [49:0] pack(input bit ovf, input int cnt, input longint acc, input int w);
    logic [63:0] a;
    logic [63:0] mask;
    a = 64'(acc);
    mask = (64'd1 << w) - 64'd1;
    a = a & mask;
    return {ovf, 9'(cnt), a[39:0]};
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 2; s++) begin
      m_acc[s] = 0;
      m_cnt[s] = 0;
      m_ovf[s] = 1'b0;
    end
    exp_a_q.delete();
    exp_b_q.delete();
  endtask

  // One accepted beat: integer add, range test, wrap or clamp, group close.
  task automatic model_accept(input int s, input logic [31:0] p, input bit last);
    int w, mx;
    longint pv, hi, lo, sum;
    w  = (s == 0) ? 40 : 33;
    mx = (s == 0) ? 256 : 4;
    pv = longint'($signed(p));
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
    sum = m_acc[s] + pv;
    if (sum > hi || sum < lo) begin
      m_ovf[s] = 1'b1;
`ifdef BOOTH_MAC_SAT_EN
      sum = (sum > hi) ? hi : lo;
`else
      sum = (sum > hi) ? sum - (longint'(1) <<< w) : sum + (longint'(1) <<< w);
`endif
    end
    m_acc[s] = sum;
    m_cnt[s]++;
    if (last || m_cnt[s] == mx) begin
      if (s == 0) exp_a_q.push_back(pack(m_ovf[s], m_cnt[s], m_acc[s], w));
      else        exp_b_q.push_back(pack(m_ovf[s], m_cnt[s], m_acc[s], w));
      m_acc[s] = 0;
      m_cnt[s] = 0;
      m_ovf[s] = 1'b0;
    end
  endtask

  // One clock: sample handshakes at the falling edge, then step past the rising edge.
  task automatic tick();
    logic [49:0] e;
    @(negedge clk);
    a_fire = a_in_valid && a_in_ready;
    b_fire = b_in_valid && b_in_ready;
    if (a_out_valid && a_out_ready) begin
      e = (exp_a_q.size() > 0) ? exp_a_q.pop_front() : 'x;
      chk("a_group", {a_out_ovf, a_out_cnt, a_out_acc}, e);
    end
    if (b_out_valid && b_out_ready) begin
      e = (exp_b_q.size() > 0) ? exp_b_q.pop_front() : 'x;
      chk("b_group", {b_out_ovf, 6'd0, b_out_cnt, 7'd0, b_out_acc}, e);
    end
    if (a_fire) model_accept(0, a_in_prod, a_in_last);
    if (b_fire) model_accept(1, b_in_prod, b_in_last);
    @(posedge clk);
    #1;
    if (rand_ready) begin
      a_out_ready = ($urandom_range(0, 3) != 0);
      b_out_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic send_beat(input int s, input logic [31:0] p, input bit last);
    bit done;
    done = 1'b0;
    if (s == 0) begin a_in_valid = 1'b1; a_in_prod = p; a_in_last = last; end
    else        begin b_in_valid = 1'b1; b_in_prod = p; b_in_last = last; end
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      done = (s == 0) ? a_fire : b_fire;
    end
    chk("send_accept", 50'(done), 50'(1));
    if (s == 0) a_in_valid = 1'b0;
    else        b_in_valid = 1'b0;
  endtask

  task automatic drain(input int s);
    int left;
    left = (s == 0) ? exp_a_q.size() : exp_b_q.size();
    for (int i = 0; i < 3000 && left > 0; i++) begin
      tick();
      left = (s == 0) ? exp_a_q.size() : exp_b_q.size();
    end
    chk("drain_empty", 50'(left), 50'(0));
  endtask

  task automatic wait_valid(input int s);
    logic v;
    v = (s == 0) ? a_out_valid : b_out_valid;
    for (int i = 0; i < 20 && !v; i++) begin
      tick();
      v = (s == 0) ? a_out_valid : b_out_valid;
    end
    chk("valid_seen", 50'(v), 50'(1));
  endtask

  initial begin
    rst_n = 1'b0;
    a_in_valid = 1'b0; a_in_prod = '0; a_in_last = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_in_prod = '0; b_in_last = 1'b0; b_out_ready = 1'b0;
    model_clear();

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 50'(a_out_valid), 50'(0));
    chk("rst_out_acc", 50'(a_out_acc), 50'(0));
    chk("rst_out_cnt", 50'(a_out_cnt), 50'(0));
    chk("rst_out_ovf", 50'(a_out_ovf), 50'(0));
    rst_n = 1'b1;
    tick();
    chk("rst_in_ready", 50'(a_in_ready), 50'(1));
    chk("rst_state", 50'(a_dbg), 50'(0));
    chk("rst_b_in_ready", 50'(b_in_ready), 50'(1));

    // single-beat group, 2-cycle latency
    a_in_valid = 1'b1; a_in_prod = 32'hFFFF_FFFF; a_in_last = 1'b1;
    tick();
    chk("single_accept", 50'(a_fire), 50'(1));
    a_in_valid = 1'b0;
    chk("single_lat1", 50'(a_out_valid), 50'(0));
    tick();
    chk("single_lat2", 50'(a_out_valid), 50'(1));
    chk("single_acc", 50'(a_out_acc), 50'(40'hFF_FFFF_FFFF));
    chk("single_cnt", 50'(a_out_cnt), 50'(1));
    chk("single_ovf", 50'(a_out_ovf), 50'(0));
    a_out_ready = 1'b1;
    tick();
    chk("single_release", 50'(a_out_valid), 50'(0));

    // back-to-back groups with out_ready high
    send_beat(0, 32'd100, 1'b0);
    send_beat(0, 32'hFFFF_FED4, 1'b0);
    send_beat(0, 32'h4000_0000, 1'b1);
    send_beat(0, 32'd5, 1'b0);
    send_beat(0, 32'd7, 1'b1);
    drain(0);

    // backpressure: result held, one beat parked in stage 1
    a_out_ready = 1'b0;
    send_beat(0, 32'd10, 1'b0);
    send_beat(0, 32'd20, 1'b1);
    send_beat(0, 32'd30, 1'b0);
    a_in_valid = 1'b1; a_in_prod = 32'd40; a_in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_in_ready", 50'(a_in_ready), 50'(0));
      chk("bp_valid", 50'(a_out_valid), 50'(1));
      chk("bp_acc", 50'(a_out_acc), 50'(30));
      chk("bp_cnt", 50'(a_out_cnt), 50'(2));
      chk("bp_state", 50'(a_dbg), 50'(1));
    end
    a_out_ready = 1'b1;
    send_beat(0, 32'd40, 1'b1);
    drain(0);

    // forced close at MAX_TERMS=256, then a 4-beat group
    for (int i = 0; i < 260; i++) send_beat(0, $urandom, (i == 259));
    drain(0);

    // randomized traffic with random backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      send_beat(0, $urandom, ($urandom_range(0, 3) == 0));
    end
    send_beat(0, $urandom, 1'b1);
    rand_ready = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b0;
    drain(0);

    // reset mid-group with a beat held in stage 1
    send_beat(0, 32'd1000, 1'b0);
    send_beat(0, 32'd2000, 1'b0);
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("midrst_valid", 50'(a_out_valid), 50'(0));
    chk("midrst_in_ready", 50'(a_in_ready), 50'(1));
    chk("midrst_cnt", 50'(a_out_cnt), 50'(0));
    tick();
    rst_n = 1'b1;
    send_beat(0, 32'd7, 1'b1);
    drain(0);

    // B: MAX_TERMS=4, five beats of 1 without in_last
    b_out_ready = 1'b1;
    for (int i = 0; i < 5; i++) send_beat(1, 32'd1, 1'b0);
    send_beat(1, 32'd1, 1'b1);
    drain(1);

    // B: ACC_W=33 near and past the positive limit
    b_out_ready = 1'b0;
    send_beat(1, 32'h7FFF_FFFF, 1'b0);
    send_beat(1, 32'h7FFF_FFFF, 1'b1);
    wait_valid(1);
    chk("b_two_acc", 50'(b_out_acc), 50'(33'h0_FFFF_FFFE));
    chk("b_two_ovf", 50'(b_out_ovf), 50'(0));
    chk("b_two_cnt", 50'(b_out_cnt), 50'(2));
    b_out_ready = 1'b1;
    tick();
    b_out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send_beat(1, 32'h7FFF_FFFF, (i == 2));
    wait_valid(1);
`ifdef BOOTH_MAC_SAT_EN
    chk("b_three_acc", 50'(b_out_acc), 50'(33'h0_FFFF_FFFF));
`else
    chk("b_three_acc", 50'(b_out_acc), 50'(33'h1_7FFF_FFFD));
`endif
    chk("b_three_ovf", 50'(b_out_ovf), 50'(1));
    b_out_ready = 1'b1;
    drain(1);

    // B: negative overflow, forced close at 4
    for (int i = 0; i < 4; i++) send_beat(1, 32'h8000_0000, 1'b0);
    drain(1);

    // B: randomized traffic
    rand_ready = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 4) == 0) tick();
      send_beat(1, $urandom, ($urandom_range(0, 5) == 0));
    end
    send_beat(1, $urandom, 1'b1);
    rand_ready = 1'b0;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    drain(1);
    drain(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
